// File: rtl/uart_tx_scheduler_if.sv
// Handshake and serial-line bundle shared by the two requesters and the UART TX scheduler.
// The scheduler takes the slave view; the requester side (or bench) takes the master view.
interface uart_tx_scheduler_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  dev0_valid;
    logic [DATA_WIDTH-1:0] dev0_data;
    logic                  dev0_ready;
    logic                  dev1_valid;
    logic [DATA_WIDTH-1:0] dev1_data;
    logic                  dev1_ready;
    logic                  tx;
    logic                  busy;
    logic                  grant_id;
    logic                  frame_done;

    modport master (
        output dev0_valid, dev0_data, dev1_valid, dev1_data,
        input  dev0_ready, dev1_ready, tx, busy, grant_id, frame_done
    );

    modport slave (
        input  dev0_valid, dev0_data, dev1_valid, dev1_data,
        output dev0_ready, dev1_ready, tx, busy, grant_id, frame_done
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Two-requester round-robin UART transmitter: accepts one byte at a time from dev0/dev1
// and serialises it as start / data (LSB first) / optional parity / stop bits.

module uart_tx_scheduler_chk (
    input logic clk,
    input logic rst,
    input logic ready0_i,
    input logic ready1_i,
    input logic idle_i,
    input logic busy_i,
    input logic tx_i,
    input logic frame_done_i
);
    a_one_ready:  assert property (@(posedge clk) disable iff (rst) !(ready0_i && ready1_i));
    a_ready_idle: assert property (@(posedge clk) disable iff (rst) (ready0_i || ready1_i) |-> idle_i);
    a_idle_line:  assert property (@(posedge clk) disable iff (rst) idle_i |-> (tx_i && !busy_i));
    a_done_busy:  assert property (@(posedge clk) disable iff (rst) frame_done_i |-> busy_i);
endmodule

module uart_tx_scheduler #(
    parameter int CLK_PER_BIT = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_EN   = 1,
    parameter int PARITY_ODD  = 0,
    parameter int STOP_BITS   = 1
) (
    input logic                clk,
    input logic                rst,
    uart_tx_scheduler_if.slave bus
);
    localparam int CNT_W = $clog2(CLK_PER_BIT);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_WIDTH - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    function automatic logic frame_parity(input logic [DATA_WIDTH-1:0] d);
        frame_parity = (^d) ^ (PARITY_ODD != 0);
    endfunction

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [3:0]            bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;

    logic                  idle_s;
    logic                  pick1_s;
    logic                  ready0_s;
    logic                  ready1_s;
    logic                  wrap_s;

    // Round-robin arbiter; on a tie the requester that did not own the last frame wins.
    always_comb begin
        idle_s = (state_q == S_IDLE) && !rst;
        if (bus.dev0_valid && bus.dev1_valid) begin
            pick1_s = !last_grant_q;
        end else begin
            pick1_s = bus.dev1_valid;
        end
        ready0_s = idle_s && bus.dev0_valid && !pick1_s;
        ready1_s = idle_s && bus.dev1_valid && pick1_s;
        wrap_s   = (cnt_q == CNT_LAST);
    end

    assign bus.dev0_ready = ready0_s;
    assign bus.dev1_ready = ready1_s;
    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.grant_id   = grant_q;
    assign bus.frame_done = frame_done_q;

    // Frame sequencer; both counters restart at every state change.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            S_IDLE: begin
                if (ready0_s || ready1_s) begin
                    state_d      = S_START;
                    cnt_d        = {CNT_W{1'b0}};
                    bit_d        = 4'd0;
                    shift_d      = pick1_s ? bus.dev1_data : bus.dev0_data;
                    parity_d     = frame_parity(shift_d);
                    grant_d      = pick1_s;
                    last_grant_d = pick1_s;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (wrap_s) begin
                    state_d = S_DATA;
                    cnt_d   = {CNT_W{1'b0}};
                    bit_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (wrap_s) begin
                    cnt_d = {CNT_W{1'b0}};
                    if (bit_q == DATA_LAST) begin
                        bit_d   = 4'd0;
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (wrap_s) begin
                    state_d = S_STOP;
                    cnt_d   = {CNT_W{1'b0}};
                    bit_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (wrap_s) begin
                    cnt_d = {CNT_W{1'b0}};
                    if (bit_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        bit_d   = 4'd0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CNT_W{1'b0}};
                bit_d   = 4'd0;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so they register in step.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_IDLE:   tx_d = 1'b1;
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_d;
            S_STOP:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_d == S_STOP) && (cnt_d == CNT_LAST) && (bit_d == STOP_LAST);
    end

    // Sequencer state, counters and latched frame source.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            bit_q        <= 4'd0;
            shift_q      <= {DATA_WIDTH{1'b0}};
            parity_q     <= 1'b0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Registered serial line and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    uart_tx_scheduler_chk u_chk (
        .clk          (clk),
        .rst          (rst),
        .ready0_i     (ready0_s),
        .ready1_i     (ready1_s),
        .idle_i       (state_q == S_IDLE),
        .busy_i       (busy_q),
        .tx_i         (tx_q),
        .frame_done_i (frame_done_q)
    );
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: four parameterisations share one clock and reset.
module tb_uart_tx_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   both_cnt = 0;
    int   busy_rdy_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_scheduler_if #(.DATA_WIDTH(8)) ba ();
    uart_tx_scheduler_if #(.DATA_WIDTH(8)) bb ();
    uart_tx_scheduler_if #(.DATA_WIDTH(8)) bc ();
    uart_tx_scheduler_if #(.DATA_WIDTH(8)) bd ();

    uart_tx_scheduler #(.CLK_PER_BIT(16), .DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
        dut_a (.clk(clk), .rst(rst), .bus(ba));
    uart_tx_scheduler #(.CLK_PER_BIT(16), .DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
        dut_b (.clk(clk), .rst(rst), .bus(bb));
    uart_tx_scheduler #(.CLK_PER_BIT(16), .DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
        dut_c (.clk(clk), .rst(rst), .bus(bc));
    uart_tx_scheduler #(.CLK_PER_BIT(4), .DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2))
        dut_d (.clk(clk), .rst(rst), .bus(bd));

    wire [3:0] tx_all   = {bd.tx, bc.tx, bb.tx, ba.tx};
    wire [3:0] busy_all = {bd.busy, bc.busy, bb.busy, ba.busy};
    wire [3:0] fd_all   = {bd.frame_done, bc.frame_done, bb.frame_done, ba.frame_done};

    always @(negedge clk) begin
        if (!rst) begin
            if (ba.dev0_ready && ba.dev1_ready) both_cnt <= both_cnt + 1;
            if ((ba.dev0_ready || ba.dev1_ready) && ba.busy) busy_rdy_cnt <= busy_rdy_cnt + 1;
        end
    end

    function automatic logic [255:0] exp_frame(input int cpb, input int dw, input int pen,
                                               input int podd, input int sb, input logic [8:0] d);
        logic [255:0] v;
        logic         par;
        int           pos;
        v   = '1;
        pos = 0;
        par = (podd != 0);
        for (int i = 0; i < dw; i++) par = par ^ d[i[3:0]];
        for (int c = 0; c < cpb; c++) begin v[pos[7:0]] = 1'b0; pos++; end
        for (int i = 0; i < dw; i++)
            for (int c = 0; c < cpb; c++) begin v[pos[7:0]] = d[i[3:0]]; pos++; end
        if (pen != 0)
            for (int c = 0; c < cpb; c++) begin v[pos[7:0]] = par; pos++; end
        for (int c = 0; c < sb * cpb; c++) begin v[pos[7:0]] = 1'b1; pos++; end
        return v;
    endfunction

    function automatic logic [255:0] ones(input int len);
        logic [255:0] v;
        v = '0;
        for (int k = 0; k < len; k++) v[k[7:0]] = 1'b1;
        return v;
    endfunction

    // Samples n consecutive cycles at negedges, starting with the current one.
    task automatic capture(input int idx, input int n, output logic [255:0] txv,
                           output logic [255:0] bv, output int fd_pos, output int fd_num);
        txv = '1; bv = '0; fd_pos = -1; fd_num = 0;
        for (int k = 0; k < n; k++) begin
            txv[k[7:0]] = tx_all[idx[1:0]];
            bv[k[7:0]]  = busy_all[idx[1:0]];
            if (fd_all[idx[1:0]] === 1'b1) begin
                if (fd_num == 0) fd_pos = k;
                fd_num++;
            end
            if (k < n - 1) @(negedge clk);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        ba.dev0_valid = 1'b1; ba.dev0_data = 8'h00; ba.dev1_valid = 1'b0; ba.dev1_data = 8'h00;
        bb.dev0_valid = 1'b0; bb.dev0_data = 8'h00; bb.dev1_valid = 1'b0; bb.dev1_data = 8'h00;
        bc.dev0_valid = 1'b0; bc.dev0_data = 8'h00; bc.dev1_valid = 1'b0; bc.dev1_data = 8'h00;
        bd.dev0_valid = 1'b0; bd.dev0_data = 8'h00; bd.dev1_valid = 1'b0; bd.dev1_data = 8'h00;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (ba.tx !== 1'b1 || ba.busy !== 1'b0) begin
            errors++; $display("FAIL reset_line: tx=%b busy=%b, want tx=1 busy=0", ba.tx, ba.busy);
        end
        checks++;
        if (ba.grant_id !== 1'b0 || ba.frame_done !== 1'b0) begin
            errors++; $display("FAIL reset_status: grant_id=%b frame_done=%b, want 0 0", ba.grant_id, ba.frame_done);
        end
        checks++;
        if (ba.dev0_ready !== 1'b0 || ba.dev1_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: r0=%b r1=%b, want 0 0", ba.dev0_ready, ba.dev1_ready);
        end
        checks++;
        if (tx_all !== 4'hF || busy_all !== 4'h0) begin
            errors++; $display("FAIL reset_all: tx=%b busy=%b, want 1111 0000", tx_all, busy_all);
        end
        ba.dev0_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_default_frame();
        logic [255:0] txv, bv, ev;
        int fp, fn;
        @(negedge clk);
        ba.dev0_data = 8'h55; ba.dev0_valid = 1'b1;
        #1;
        checks++;
        if (ba.dev0_ready !== 1'b1 || ba.dev1_ready !== 1'b0) begin
            errors++; $display("FAIL t1_ready: r0=%b r1=%b, want 1 0", ba.dev0_ready, ba.dev1_ready);
        end
        @(posedge clk);
        @(negedge clk);
        ba.dev0_valid = 1'b0;
        checks++;
        if (ba.grant_id !== 1'b0) begin
            errors++; $display("FAIL t1_grant: got %b want 0", ba.grant_id);
        end
        capture(0, 177, txv, bv, fp, fn);
        ev = exp_frame(16, 8, 1, 0, 1, 9'h055);
        checks++;
        if (txv !== ev) begin
            errors++; $display("FAIL t1_frame: got %h want %h", txv, ev);
        end
        checks++;
        if (fp !== 175 || fn !== 1) begin
            errors++; $display("FAIL t1_done: pos=%0d count=%0d, want pos=175 count=1", fp, fn);
        end
        checks++;
        if (bv !== ones(176)) begin
            errors++; $display("FAIL t1_busy: got %h want %h", bv, ones(176));
        end
    endtask

    task automatic test_round_robin();
        int n, t, t_prev;
        logic who, exp_who;
        apply_reset();
        @(negedge clk);
        ba.dev0_data = 8'h11; ba.dev1_data = 8'h22;
        ba.dev0_valid = 1'b1; ba.dev1_valid = 1'b1;
        t_prev = 0;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            #1;
            while (!(ba.dev0_ready || ba.dev1_ready) && n < 400) begin
                @(negedge clk); #1; n++;
            end
            checks++;
            if (n >= 400) begin
                errors++; $display("FAIL t2_timeout: waited %0d cycles, want acceptance", n);
                ba.dev0_valid = 1'b0; ba.dev1_valid = 1'b0;
                return;
            end
            who = ba.dev1_ready;
            exp_who = (i % 2 == 1);
            t = cyc;
            checks++;
            if (who !== exp_who) begin
                errors++; $display("FAIL t2_order%0d: got dev%0d want dev%0d", i, who, exp_who);
            end
            if (i > 0) begin
                checks++;
                if (t - t_prev !== 177) begin
                    errors++; $display("FAIL t2_spacing%0d: got %0d want 177", i, t - t_prev);
                end
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (ba.grant_id !== who) begin
                errors++; $display("FAIL t2_grant%0d: got %b want %b", i, ba.grant_id, who);
            end
            t_prev = t;
        end
        ba.dev0_valid = 1'b0; ba.dev1_valid = 1'b0;
        n = 0;
        while (ba.busy && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (ba.busy !== 1'b0) begin
            errors++; $display("FAIL t2_drain: busy=%b want 0", ba.busy);
        end
    endtask

    task automatic test_dev1_only();
        logic [7:0] bytes [3];
        logic [255:0] txv, bv, ev;
        int fp, fn;
        bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'hFF;
        @(negedge clk);
        ba.dev1_data = bytes[0]; ba.dev1_valid = 1'b1;
        #1;
        checks++;
        if (ba.dev1_ready !== 1'b1 || ba.dev0_ready !== 1'b0) begin
            errors++; $display("FAIL t3_ready: r0=%b r1=%b, want 0 1", ba.dev0_ready, ba.dev1_ready);
        end
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (i < 2) ba.dev1_data = bytes[i + 1];
            else ba.dev1_valid = 1'b0;
            checks++;
            if (ba.grant_id !== 1'b1) begin
                errors++; $display("FAIL t3_grant%0d: got %b want 1", i, ba.grant_id);
            end
            capture(0, 177, txv, bv, fp, fn);
            ev = exp_frame(16, 8, 1, 0, 1, {1'b0, bytes[i]});
            checks++;
            if (txv !== ev) begin
                errors++; $display("FAIL t3_frame%0d: got %h want %h", i, txv, ev);
            end
            checks++;
            if (fp !== 175 || fn !== 1) begin
                errors++; $display("FAIL t3_done%0d: pos=%0d count=%0d, want 175 1", i, fp, fn);
            end
            checks++;
            if (ba.dev1_ready !== (i < 2)) begin
                errors++; $display("FAIL t3_idle_ready%0d: got %b want %b", i, ba.dev1_ready, (i < 2));
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [255:0] txv, bv, ev;
        int fp, fn;
        @(negedge clk);
        ba.dev0_data = 8'hF0; ba.dev0_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ba.dev0_valid = 1'b0;
        repeat (72) @(negedge clk);
        checks++;
        if (ba.tx !== 1'b0 || ba.busy !== 1'b1) begin
            errors++; $display("FAIL t4_bit3: tx=%b busy=%b, want 0 1", ba.tx, ba.busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ba.tx !== 1'b1 || ba.busy !== 1'b0 || ba.frame_done !== 1'b0) begin
            errors++; $display("FAIL t4_async: tx=%b busy=%b fd=%b, want 1 0 0", ba.tx, ba.busy, ba.frame_done);
        end
        @(negedge clk);
        rst = 1'b0;
        capture(0, 200, txv, bv, fp, fn);
        checks++;
        if (fn !== 0 || txv !== {256{1'b1}} || bv !== 256'd0) begin
            errors++; $display("FAIL t4_quiet: fd_count=%0d tx=%h busy=%h, want 0 all-ones zero", fn, txv, bv);
        end
        @(negedge clk);
        ba.dev0_data = 8'h81; ba.dev0_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ba.dev0_valid = 1'b0;
        capture(0, 177, txv, bv, fp, fn);
        ev = exp_frame(16, 8, 1, 0, 1, 9'h081);
        checks++;
        if (txv !== ev || fp !== 175 || fn !== 1) begin
            errors++; $display("FAIL t4_frame: got %h pos=%0d want %h pos=175", txv, fp, ev);
        end
    endtask

    task automatic test_parity_variants();
        logic [255:0] txv, bv, ev;
        int fp, fn;
        @(negedge clk);
        bb.dev0_data = 8'h00; bb.dev0_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bb.dev0_valid = 1'b0;
        capture(1, 177, txv, bv, fp, fn);
        ev = exp_frame(16, 8, 1, 1, 1, 9'h000);
        checks++;
        if (txv[152] !== 1'b1) begin
            errors++; $display("FAIL t5_odd_parity: got %b want 1", txv[152]);
        end
        checks++;
        if (txv !== ev || fp !== 175) begin
            errors++; $display("FAIL t5_odd_frame: got %h pos=%0d want %h pos=175", txv, fp, ev);
        end
        @(negedge clk);
        bc.dev0_data = 8'h5A; bc.dev0_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bc.dev0_valid = 1'b0;
        capture(2, 161, txv, bv, fp, fn);
        ev = exp_frame(16, 8, 0, 0, 1, 9'h05A);
        checks++;
        if (txv !== ev) begin
            errors++; $display("FAIL t5_nopar_frame: got %h want %h", txv, ev);
        end
        checks++;
        if (fp !== 159 || fn !== 1 || bv !== ones(160)) begin
            errors++; $display("FAIL t5_nopar_len: pos=%0d count=%0d busy=%h, want 159 1 %h", fp, fn, bv, ones(160));
        end
    endtask

    task automatic test_two_stop();
        logic [255:0] txv, bv, ev;
        int fp, fn;
        @(negedge clk);
        bd.dev0_data = 8'h0F; bd.dev0_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bd.dev0_valid = 1'b0;
        capture(3, 49, txv, bv, fp, fn);
        ev = exp_frame(4, 8, 1, 0, 2, 9'h00F);
        checks++;
        if (txv !== ev) begin
            errors++; $display("FAIL t6_frame: got %h want %h", txv, ev);
        end
        checks++;
        if (txv[47:39] !== 9'h1FE) begin
            errors++; $display("FAIL t6_stop: got %b want 111111110", txv[47:39]);
        end
        checks++;
        if (fp !== 47 || fn !== 1 || bv !== ones(48)) begin
            errors++; $display("FAIL t6_len: pos=%0d count=%0d busy=%h, want 47 1 %h", fp, fn, bv, ones(48));
        end
    endtask

    task automatic test_ready_monitor();
        checks++;
        if (both_cnt !== 0 || busy_rdy_cnt !== 0) begin
            errors++; $display("FAIL ready_rules: both=%0d busy_ready=%0d, want 0 0", both_cnt, busy_rdy_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_default_frame();
        test_round_robin();
        test_dev1_only();
        test_reset_mid_frame();
        test_parity_variants();
        test_two_stop();
        test_ready_monitor();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
